// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb -- two-requester arbiter for one shared single-port memory.
//
// Purpose
//   An instruction-fetch port and a data port share one memory. Only one
//   access is in flight at a time. The data side wins when both ask in the
//   same cycle, so the older instruction's load/store goes first. Each
//   requester holds its request until it sees a one-cycle ack. The read data
//   for each side is registered and held between acks.
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN)
//   When the macro is defined, a busy access that gets no mem_ack_i for
//   TO_CYCLES cycles is aborted. The requester is acked with 32'hDEADBEEF and
//   the sticky err_o flag is set. When the macro is undefined, a busy access
//   waits forever and err_o is tied low.
//
// Parameters
//   TO_CYCLES     busy-cycle limit before a timeout abort (1..255)
//
// Ports
//   clk_i         clock; all state changes on the rising edge
//   reset_i       asynchronous, active-high reset
//   if_req_i      fetch read request, held until if_ack_o
//   if_addr_i     fetch byte address
//   if_ack_o      one-cycle fetch completion pulse
//   if_rdata_o    registered fetch data
//   dm_rd_i       data read request, held until dm_ack_o
//   dm_wr_i       data write request, held until dm_ack_o
//   dm_addr_i     data byte address
//   dm_wdata_i    store data
//   dm_ack_o      one-cycle data completion pulse
//   dm_rdata_o    registered load data
//   if_stall_o    fetch request pending and not yet acked
//   dm_stall_o    data request pending and not yet acked
//   mem_req_o     registered memory request
//   mem_we_o      registered memory write enable
//   mem_addr_o    registered memory address
//   mem_wdata_o   registered memory store data
//   mem_ack_i     memory completion; mem_rdata_i is valid in the same cycle
//   mem_rdata_i   memory read data
//   err_o         sticky timeout flag
// -----------------------------------------------------------------------------
module mem_arb #(
  parameter int TO_CYCLES = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_rd_i,
  input  logic        dm_wr_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic        if_stall_o,
  output logic        dm_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  // Reject an out-of-range limit at elaboration.
  if (TO_CYCLES < 1 || TO_CYCLES > 255) begin : g_bad_to_cycles
    $error("mem_arb: TO_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_DM_BUSY = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  logic        dm_req;
  logic        done;
  logic [31:0] rsp_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = TO_CYCLES[7:0];
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  assign dm_req = dm_rd_i | dm_wr_i;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    done        = 1'b0;
    rsp_data    = mem_rdata_i;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // A requester whose ack is high this cycle is still holding its
        // request from the finished access; it must not be granted again.
        // The registered ack doubles as that mask. mem_ack_i is ignored here.
        if (dm_req && !dm_ack_q) begin
          state_d     = ST_DM_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_wr_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end else if (if_req_i && !if_ack_q) begin
          state_d     = ST_IF_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = 32'd0;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end
      end

      ST_IF_BUSY, ST_DM_BUSY: begin
        // The access runs to completion even if the requester drops its
        // request; only mem_ack_i (or a timeout) ends it.
        if (mem_ack_i) begin
          done = 1'b1;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q + 8'd1 == TO_LIM) begin
          done     = 1'b1;
          rsp_data = 32'hDEAD_BEEF;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
        if (done) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          // Read data is loaded on writes as well; the requester ignores it.
          if (state_q == ST_DM_BUSY) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = rsp_data;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = rsp_data;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  // Stall flags follow the live request so the pipeline can hold in the
  // same cycle it raises a request.
  assign if_stall_o = if_req_i & ~if_ack_q;
  assign dm_stall_o = dm_req & ~dm_ack_q;

endmodule
